ads5404_tx_framer: RTL and testbench

Transmit-side framer that produces ADS5404-format sample-pair streams (two samples per clock plus overrange and sync markers) for loopback testing of the ADS5404 capture path and for driving DAC/emulator outputs. It buffers user sample pairs in a small FIFO, or generates test patterns, and emits registered words intended for ODDR/OBUFDS primitives placed outside this block. It sits on the user clock domain; all logic is single-clock.

---
 rtl/ads5404_tx_framer_if.sv | 14 +
 rtl/ads5404_tx_framer.sv | 203 ++++++++++++++++++++
 tb/tb_ads5404_tx_framer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ads5404_tx_framer_if.sv
// Input sample-pair stream for ads5404_tx_framer: a valid/ready handshake
// carrying two samples (d0 earlier than d1) and their overrange flags.
interface ads5404_tx_framer_if #(
  parameter int NBITS = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_d0;
  logic [NBITS-1:0] in_d1;
  logic [1:0]       in_ovr;

  modport master (output in_valid, in_d0, in_d1, in_ovr, input in_ready);
  modport slave  (input in_valid, in_d0, in_d1, in_ovr, output in_ready);
endinterface

// File: rtl/ads5404_tx_framer.sv
// ADS5404-format transmit framer: buffers user sample pairs in a small FIFO
// (or generates test patterns) and emits registered sample pairs with
// overrange and sync markers for external ODDR/OBUFDS primitives.
// Optional feature macro: ADS5404_TX_PATTERN_EN enables the ramp, toggle and
// midscale pattern modes; without it the mode input is ignored (FIFO only).
module ads5404_tx_framer #(
  parameter int NBITS       = 12,
  parameter int FIFO_AW     = 4,
  parameter int SYNC_PERIOD = 256
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic                     sync_req,
  ads5404_tx_framer_if.slave       in_if,
  output logic [NBITS-1:0]         out_d_0,
  output logic [NBITS-1:0]         out_d_1,
  output logic                     out_ovr_0,
  output logic                     out_ovr_1,
  output logic                     out_sync_0,
  output logic                     out_sync_1,
  output logic                     underflow,
  output logic [15:0]              underflow_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [NBITS-1:0] MID      = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_HALF = (FIFO_AW+1)'(DEPTH / 2);

  // Alternating-bit word with LSB 0 (0xAAA for 12 bits).
  function automatic logic [NBITS-1:0] alt_bits();
    logic [NBITS-1:0] v;
    for (int i = 0; i < NBITS; i++) v[i] = i[0];
    return v;
  endfunction
  localparam logic [NBITS-1:0] ALT = alt_bits();

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_e;
  typedef enum logic [1:0] {MODE_FIFO, MODE_RAMP, MODE_TOGGLE, MODE_MID} mode_e;
  typedef struct packed {
    logic [1:0]       ovr;
    logic [NBITS-1:0] d1;
    logic [NBITS-1:0] d0;
  } pair_t;

  mode_e mode_eff;
`ifdef ADS5404_TX_PATTERN_EN
  assign mode_eff = mode_e'(mode);
`else
  logic unused_mode;
  assign mode_eff    = MODE_FIFO;
  assign unused_mode = ^mode;
`endif

  state_e             state_q, state_d;
  pair_t              mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic [NBITS-1:0]   ramp_q, ramp_d;
  logic [PW-1:0]      per_q, per_d, eff_per;
  logic               sync_req_q, sync_req_d, sync_prev_q, sync_prev_d;
  logic [NBITS-1:0]   out_d0_q, out_d0_d, out_d1_q, out_d1_d;
  logic [1:0]         out_ovr_q, out_ovr_d;
  logic               out_sync_q, out_sync_d;
  logic               underflow_q, underflow_d;
  logic [15:0]        underflow_cnt_q, underflow_cnt_d;
  logic               push, pop, rise;
  pair_t              head;

  assign head = mem[rd_ptr_q];

  // FIFO storage write port.
  // NOTE: the sample memory has no reset; pointers and count define validity,
  // which keeps it mappable to distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{ovr: in_if.in_ovr, d1: in_if.in_d1, d0: in_if.in_d0};
  end

  // Next-state, FIFO bookkeeping, sync scheduling and output word selection.
  // NOTE: every signal gets a default first so no path leaves a latch.
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    ramp_d          = '0;
    per_d           = '0;
    eff_per         = per_q;
    out_d0_d        = MID;
    out_d1_d        = MID;
    out_ovr_d       = '0;
    out_sync_d      = 1'b0;
    underflow_d     = 1'b0;
    underflow_cnt_d = underflow_cnt_q;
    sync_req_d      = sync_req;
    sync_prev_d     = sync_req_q;
    rise            = sync_req_q && !sync_prev_q;
    push            = in_if.in_valid && in_ready_q;
    pop             = 1'b0;

    case (state_q)
      IDLE: if (enable) state_d = ARM;
      ARM: begin
        if (!enable) state_d = IDLE;
        else if (mode_eff != MODE_FIFO || count_q >= CNT_HALF) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = IDLE;
        // A request restarts the period as if the counter had just wrapped;
        // coincident request and wrap collapse into one marker.
        eff_per    = rise ? '0 : per_q;
        out_sync_d = (eff_per == '0);
        if (SYNC_PERIOD == 0)                    per_d = PW'(1);
        else if (eff_per == PW'(SYNC_PERIOD-1))  per_d = '0;
        else                                     per_d = eff_per + 1'b1;
        case (mode_eff)
          MODE_FIFO: begin
            if (count_q != '0) begin
              pop       = 1'b1;
              out_d0_d  = head.d0;
              out_d1_d  = head.d1;
              out_ovr_d = head.ovr;
            end else begin
              underflow_d = 1'b1;
              if (underflow_cnt_q != '1) underflow_cnt_d = underflow_cnt_q + 1'b1;
            end
          end
          MODE_RAMP: begin
            out_d0_d = ramp_q;
            out_d1_d = ramp_q + 1'b1;
            ramp_d   = ramp_q + NBITS'(2);
          end
          MODE_TOGGLE: begin
            out_d0_d = ALT;
            out_d1_d = ~ALT;
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
    in_ready_d = (count_d != CNT_FULL);
  end

  // State and output registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      in_ready_q      <= 1'b0;
      ramp_q          <= '0;
      per_q           <= '0;
      sync_req_q      <= 1'b0;
      sync_prev_q     <= 1'b0;
      out_d0_q        <= MID;
      out_d1_q        <= MID;
      out_ovr_q       <= '0;
      out_sync_q      <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      in_ready_q      <= in_ready_d;
      ramp_q          <= ramp_d;
      per_q           <= per_d;
      sync_req_q      <= sync_req_d;
      sync_prev_q     <= sync_prev_d;
      out_d0_q        <= out_d0_d;
      out_d1_q        <= out_d1_d;
      out_ovr_q       <= out_ovr_d;
      out_sync_q      <= out_sync_d;
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign out_d_0        = out_d0_q;
  assign out_d_1        = out_d1_q;
  assign out_ovr_0      = out_ovr_q[0];
  assign out_ovr_1      = out_ovr_q[1];
  assign out_sync_0     = out_sync_q;
  assign out_sync_1     = 1'b0;
  assign underflow      = underflow_q;
  assign underflow_cnt  = underflow_cnt_q;
endmodule

// File: tb/tb_ads5404_tx_framer.sv
// Self-checking bench for ads5404_tx_framer: directed phases with randomized
// data and control, compared every cycle against a transaction-level model.
module tb_ads5404_tx_framer;
  localparam int NB = 12;
  localparam int SP = 8;
  localparam logic [NB-1:0] MID = 12'h800;
`ifdef ADS5404_TX_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nrst, enable, sync_req;
  logic [1:0]    mode;
  logic [NB-1:0] out_d_0, out_d_1;
  logic          out_ovr_0, out_ovr_1, out_sync_0, out_sync_1, underflow;
  logic [15:0]   underflow_cnt;

  ads5404_tx_framer_if #(.NBITS(NB)) bus ();

  ads5404_tx_framer #(.NBITS(NB), .FIFO_AW(4), .SYNC_PERIOD(SP)) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .mode(mode), .sync_req(sync_req),
    .in_if(bus), .out_d_0(out_d_0), .out_d_1(out_d_1),
    .out_ovr_0(out_ovr_0), .out_ovr_1(out_ovr_1),
    .out_sync_0(out_sync_0), .out_sync_1(out_sync_1),
    .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_ARM, P_RUN} phase_e;
  typedef struct packed {logic [1:0] ovr; logic [NB-1:0] d1; logic [NB-1:0] d0;} pair_t;

  pair_t   mq[$];
  phase_e  ph = P_IDLE;
  bit      first_run, ramp_live, s1, s2, rdy;
  int      since, ucnt;
  logic [NB-1:0] m_ramp;
  logic [NB-1:0] e_d0 = MID, e_d1 = MID;
  bit      e_o0, e_o1, e_sync, e_uf;

  int vectors = 0;
  int miscompares = 0;

  // Advance the model by one clock using the inputs present at that edge.
  function automatic void model_step();
    bit acc, rise;
    int md;
    phase_e nxt;
    pair_t p;
    logic [NB-1:0] r;
    if (!nrst) begin
      mq.delete();
      ph = P_IDLE; rdy = 0; ucnt = 0; s1 = 0; s2 = 0; ramp_live = 0;
      e_d0 = MID; e_d1 = MID; e_o0 = 0; e_o1 = 0; e_sync = 0; e_uf = 0;
      return;
    end
    acc  = bus.in_valid && rdy;
    rise = s1 && !s2;
    md   = PAT_EN ? int'(mode) : 0;
    nxt  = ph;
    e_d0 = MID; e_d1 = MID; e_o0 = 0; e_o1 = 0; e_sync = 0; e_uf = 0;
    case (ph)
      P_IDLE: if (enable) nxt = P_ARM;
      P_ARM: begin
        if (!enable) nxt = P_IDLE;
        else if (md != 0 || mq.size() >= 8) begin nxt = P_RUN; first_run = 1; end
      end
      P_RUN: begin
        e_sync    = first_run || rise || (since == SP);
        since     = e_sync ? 1 : since + 1;
        first_run = 0;
        case (md)
          0: begin
            if (mq.size() > 0) begin
              p = mq.pop_front();
              e_d0 = p.d0; e_d1 = p.d1; e_o0 = p.ovr[0]; e_o1 = p.ovr[1];
            end else begin
              e_uf = 1;
              if (ucnt < 65535) ucnt++;
            end
          end
          1: begin
            r = ramp_live ? m_ramp : '0;
            e_d0 = r; e_d1 = r + 1'b1; m_ramp = r + 12'd2;
          end
          2: begin e_d0 = 12'hAAA; e_d1 = 12'h555; end
          default: ;
        endcase
        if (!enable) nxt = P_IDLE;
      end
      default: ;
    endcase
    ramp_live = (ph == P_RUN) && (md == 1);
    if (acc) mq.push_back('{ovr: bus.in_ovr, d1: bus.in_d1, d0: bus.in_d0});
    rdy = mq.size() < 16;
    s2 = s1; s1 = sync_req;
    ph = nxt;
  endfunction

  // One clock: model at the edge, compare on the following falling edge.
  task automatic step(input string tag);
    logic [45:0] obs, expv;
    @(posedge clk);
    model_step();
    @(negedge clk);
    obs  = {out_d_0, out_d_1, out_ovr_0, out_ovr_1, out_sync_0, out_sync_1,
            underflow, underflow_cnt, bus.in_ready};
    expv = {e_d0, e_d1, e_o0, e_o1, e_sync, 1'b0, e_uf, 16'(ucnt), rdy};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive_pair(input logic [NB-1:0] a, input logic [NB-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_d0    = a;
    bus.in_d1    = b;
    bus.in_ovr   = 2'($urandom);
  endtask

  initial begin
    nrst = 0; enable = 0; mode = 0; sync_req = 0;
    bus.in_valid = 0; bus.in_d0 = '0; bus.in_d1 = '0; bus.in_ovr = '0;

    // Reset state, then release: in_ready rises on the first cycle after.
    repeat (3) step("reset");
    nrst = 1;
    step("release");

    // Fill to full with ramp-numbered pairs; the 17th offer is ignored.
    for (int k = 0; k < 17; k++) begin
      drive_pair(12'(2*k), 12'(2*k+1));
      step("fill");
    end
    bus.in_valid = 0;

    // Stream the buffered pairs out in order, then run into underflow.
    enable = 1;
    for (int k = 0; k < 24; k++) step("drain");

    // Enable drop with 5 pairs buffered, top up, re-enable and resume.
    enable = 0;
    repeat (2) step("stop");
    for (int k = 0; k < 12; k++) begin
      drive_pair(12'($urandom), 12'($urandom));
      step("refill");
    end
    bus.in_valid = 0;
    enable = 1;
    for (int i = 0; i < 50 && mq.size() != 5; i++) step("run_to_5");
    enable = 0;
    for (int k = 0; k < 4; k++) begin
      drive_pair(12'($urandom), 12'($urandom));
      step("paused");
    end
    bus.in_valid = 0;
    enable = 1;
    repeat (20) step("resume");

    // Randomized control and data, including occasional resets.
    for (int i = 0; i < 600; i++) begin
      nrst         = ($urandom_range(0, 63) != 0);
      enable       = ($urandom_range(0, 15) != 0);
      mode         = 2'($urandom);
      sync_req     = 1'($urandom);
      bus.in_valid = 1'($urandom);
      bus.in_d0    = 12'($urandom);
      bus.in_d1    = 12'($urandom);
      bus.in_ovr   = 2'($urandom);
      step("random");
    end

    // Clean start in FIFO mode, then sweep sync_req phase against the period.
    nrst = 0; enable = 0; mode = 0; sync_req = 0; bus.in_valid = 0;
    step("reset2");
    nrst = 1; enable = 1;
    for (int k = 0; k < 8; k++) begin
      drive_pair(12'($urandom), 12'($urandom));
      step("prime");
    end
    bus.in_valid = 0;
    for (int off = 0; off < 10; off++) begin
      sync_req = 1;
      repeat (2) step("sync_hi");
      sync_req = 0;
      repeat (off + 3) step("sync_lo");
    end

    // Long starvation: underflow every cycle, counter saturates at 0xFFFF.
    repeat (65600) step("saturate");

    // Pattern modes (FIFO mode with underflow when patterns are compiled out).
    mode = 1; repeat (2100) step("ramp");
    mode = 2; repeat (20) step("toggle");
    mode = 1; repeat (10) step("ramp_restart");
    mode = 3; repeat (20) step("midscale");
    mode = 0; repeat (5) step("back_to_fifo");

    // Reset mid-RUN with data buffered; afterwards try mode 1 from empty.
    for (int k = 0; k < 6; k++) begin
      drive_pair(12'($urandom), 12'($urandom));
      step("pre_abort");
    end
    bus.in_valid = 0;
    nrst = 0;
    step("abort");
    nrst = 1; enable = 1; mode = 1;
    repeat (10) step("post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
